// File: rtl/rca_multibyte_seq_if.sv
// Request/result bundle for the multibyte add/sub sequencer.
// master drives operands and res_ready; slave returns busy and result fields.
interface rca_multibyte_seq_if #(
   parameter int NBYTES = 4
);
   localparam int W = 8 * NBYTES;

   logic         start;
   logic         sub;
   logic         cin;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         zero;

   modport master (
      output start, sub, cin, op_a, op_b, res_ready,
      input  busy, res_valid, result, cout, ovf, zero
   );

   modport slave (
      input  start, sub, cin, op_a, op_b, res_ready,
      output busy, res_valid, result, cout, ovf, zero
   );
endinterface

// File: rtl/rca_multibyte_seq.sv
// Byte-serial multi-precision add/sub built on one 8-bit ripple adder.
// Ports: clk, rst_n (sync, active-low), bus (slave side of request/result).
module rca8b (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       ci,
   output logic [7:0] s,
   output logic       co
);
   logic [8:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < 8; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[8];
endmodule

module rca_multibyte_seq #(
   parameter int NBYTES = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   rca_multibyte_seq_if.slave  bus
);
   localparam int W = 8 * NBYTES;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] LAST = 3'(NBYTES - 1);

   logic [1:0]   state;
   logic [2:0]   idx;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic [W-1:0] res_q;
   logic [W-1:0] res_nx;
   logic         carry_q;
   logic         cout_q;
   logic         ovf_q;
   logic         zero_q;

   logic [5:0]   lo;
   logic [7:0]   a_byte;
   logic [7:0]   b_byte;
   logic [7:0]   sum;
   logic         co;

   assign lo     = {idx, 3'b000};
   assign a_byte = a_q[lo +: 8];
   assign b_byte = b_q[lo +: 8];

   rca8b u_add (
      .a  (a_byte),
      .b  (b_byte),
      .ci (carry_q),
      .s  (sum),
      .co (co)
   );

   // Result with the current byte merged in, so zero sees the final byte.
   always_comb begin
      res_nx          = res_q;
      res_nx[lo +: 8] = sum;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.op_a;
                  // Subtract as A + ~B + 1.
                  b_q     <= bus.sub ? ~bus.op_b : bus.op_b;
                  carry_q <= bus.sub | bus.cin;
                  idx     <= '0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               res_q   <= res_nx;
               carry_q <= co;
               idx     <= idx + 3'd1;
               if (idx == LAST) begin
                  cout_q <= co;
                  // Carry into the MSB recovered from its sum bit.
                  ovf_q  <= (a_byte[7] ^ b_byte[7] ^ sum[7]) ^ co;
                  zero_q <= (res_nx == '0);
                  idx    <= '0;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.res_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = (state != S_IDLE);
   assign bus.res_valid = (state == S_DONE);
   assign bus.result    = res_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_rca_multibyte_seq.sv
// Self-checking bench for rca_multibyte_seq (NBYTES=4).
// Directed table, backpressure/reset sequences and random ops vs a model.
module tb_rca_multibyte_seq;
   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   rca_multibyte_seq_if #(.NBYTES(NBYTES)) bus ();

   rca_multibyte_seq #(.NBYTES(NBYTES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic         ci;
      logic [W-1:0] r;
      logic         c;
      logic         o;
      logic         z;
   } vec_t;

   vec_t vt [9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic void model(
      input  logic [W-1:0] a,
      input  logic [W-1:0] b,
      input  logic         s,
      input  logic         ci,
      output logic [W-1:0] r,
      output logic         c,
      output logic         o,
      output logic         z
   );
      logic [W-1:0] bb;
      logic [W:0]   full;
      bb   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : ci)};
      r    = full[W-1:0];
      c    = full[W];
      o    = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
      z    = (r == '0);
   endfunction

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = '0;
         1:       v = '1;
         2:       v = 32'h8000_0000;
         3:       v = 32'h7fff_ffff;
         4:       v = 32'($urandom_range(0, 3));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic do_op(
      input string        tag,
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic         s,
      input logic         ci,
      input logic [W-1:0] er,
      input logic         ec,
      input logic         eo,
      input logic         ez,
      input bit           noisy
   );
      int hold;
      bus.start     = 1'b1;
      bus.sub       = s;
      bus.cin       = ci;
      bus.op_a      = a;
      bus.op_b      = b;
      bus.res_ready = noisy ? 1'($urandom) : 1'b0;
      step();
      for (int i = 0; i < NBYTES; i++) begin
         chk({tag, ".run_busy"}, bus.busy, 1);
         chk({tag, ".run_valid"}, bus.res_valid, 0);
         bus.start     = noisy ? 1'($urandom) : 1'b0;
         bus.sub       = 1'($urandom);
         bus.cin       = 1'($urandom);
         bus.op_a      = $urandom;
         bus.op_b      = $urandom;
         bus.res_ready = noisy ? 1'($urandom) : 1'b0;
         step();
      end
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      hold = noisy ? $urandom_range(0, 3) : 0;
      for (int i = 0; i <= hold; i++) begin
         chk({tag, ".valid"}, bus.res_valid, 1);
         chk({tag, ".busy"}, bus.busy, 1);
         chk({tag, ".result"}, bus.result, er);
         chk({tag, ".cout"}, bus.cout, ec);
         chk({tag, ".ovf"}, bus.ovf, eo);
         chk({tag, ".zero"}, bus.zero, ez);
         if (i < hold) begin
            bus.start = noisy ? 1'($urandom) : 1'b0;
            step();
         end
      end
      bus.res_ready = 1'b1;
      bus.start     = 1'b0;
      step();
      bus.res_ready = 1'b0;
      chk({tag, ".post_valid"}, bus.res_valid, 0);
      chk({tag, ".post_busy"}, bus.busy, 0);
      chk({tag, ".post_result"}, bus.result, er);
   endtask

   initial begin
      logic [W-1:0] a, b, r;
      logic         s, ci, c, o, z;

      vt[0] = '{32'h0000_00ff, 32'h0000_0001, 1'b0, 1'b0,
                32'h0000_0100, 1'b0, 1'b0, 1'b0};
      vt[1] = '{32'hffff_ffff, 32'h0000_0001, 1'b0, 1'b0,
                32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vt[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1,
                32'h0000_0001, 1'b0, 1'b0, 1'b0};
      vt[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1,
                32'hffff_fffe, 1'b0, 1'b0, 1'b0};
      vt[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0,
                32'h0000_0002, 1'b1, 1'b0, 1'b0};
      vt[5] = '{32'h7fff_ffff, 32'h0000_0001, 1'b0, 1'b0,
                32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vt[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0,
                32'h7fff_ffff, 1'b1, 1'b1, 1'b0};
      vt[7] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0,
                32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vt[8] = '{32'h00ff_ff00, 32'h0000_0100, 1'b0, 1'b0,
                32'h0100_0000, 1'b0, 1'b0, 1'b0};

      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.sub       = 1'b0;
      bus.cin       = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.res_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      chk("reset.busy", bus.busy, 0);
      chk("reset.valid", bus.res_valid, 0);
      chk("reset.result", bus.result, 0);
      chk("reset.cout", bus.cout, 0);
      chk("reset.ovf", bus.ovf, 0);
      chk("reset.zero", bus.zero, 0);
      step();
      chk("idle.busy", bus.busy, 0);

      for (int i = 0; i < 9; i++) begin
         do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].s,
               vt[i].ci, vt[i].r, vt[i].c, vt[i].o, vt[i].z, 1'b0);
      end

      // Backpressure: result held, starts ignored, handshake start ignored.
      bus.start = 1'b1;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      bus.op_a  = 32'h1234_5678;
      bus.op_b  = 32'h1111_1111;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < NBYTES; i++) step();
      for (int i = 0; i < 10; i++) begin
         chk("bp.valid", bus.res_valid, 1);
         chk("bp.busy", bus.busy, 1);
         chk("bp.result", bus.result, 32'h2345_6789);
         bus.start = 1'b1;
         bus.sub   = 1'($urandom);
         bus.op_a  = $urandom;
         bus.op_b  = $urandom;
         step();
      end
      bus.res_ready = 1'b1;
      bus.start     = 1'b1;
      step();
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      chk("bp.hs_busy", bus.busy, 0);
      chk("bp.hs_valid", bus.res_valid, 0);
      chk("bp.hs_result", bus.result, 32'h2345_6789);
      step();
      chk("bp.no_queue_busy", bus.busy, 0);
      do_op("bp_next", 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0,
            32'hffff_fff0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset asserted during the second RUN cycle.
      bus.start = 1'b1;
      bus.sub   = 1'b0;
      bus.cin   = 1'b1;
      bus.op_a  = 32'h0101_0101;
      bus.op_b  = 32'h0202_0202;
      step();
      bus.start = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rst_run.busy", bus.busy, 0);
      chk("rst_run.valid", bus.res_valid, 0);
      chk("rst_run.result", bus.result, 0);
      chk("rst_run.cout", bus.cout, 0);
      chk("rst_run.ovf", bus.ovf, 0);
      chk("rst_run.zero", bus.zero, 0);
      do_op("rst_next", 32'hdead_beef, 32'h2152_4111, 1'b0, 1'b0,
            32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);

      for (int n = 0; n < 40; n++) begin
         a  = pick();
         b  = pick();
         s  = 1'($urandom);
         ci = 1'($urandom);
         model(a, b, s, ci, r, c, o, z);
         do_op($sformatf("rnd%0d", n), a, b, s, ci, r, c, o, z, 1'b1);
         if ($urandom_range(0, 2) == 0) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rca_multibyte_seq.md
Name: rca_multibyte_seq

Overview:
- Multi-precision add/subtract sequencer built around the team's 8-bit ripple-carry adder (rca8b), instantiated once inside the block.
- Accepts two NBYTES-wide operands through a start/busy handshake and processes them one byte per cycle, LSB byte first, carrying between bytes in a register.
- Presents the full-width result, carry and flags through a valid/ready handshake.
- Lets designs that own only the single 8-bit adder perform 16/32/64-bit arithmetic without adding wider adders.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 2..8; total width W = 8*NBYTES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  request a new operation; accepted only when busy=0.
- sub  input  1  0 = A+B+cin, 1 = A-B (cin ignored); sampled with start.
- cin  input  1  carry-in for add; sampled with start.
- op_a  input  W  operand A; sampled with start.
- op_b  input  W  operand B; sampled with start.
- busy  output  1  high from the accept cycle until the result handshake completes.
- res_valid  output  1  result fields are valid.
- res_ready  input  1  consumer accepts the result.
- result  output  W  sum/difference.
- cout  output  1  final carry out; for sub, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; busy, res_valid, result, cout, ovf and zero all 0; byte index 0; internal carry 0; operand registers 0.
  - Reset overrides everything, including mid-RUN and DONE. The operation in progress is discarded and no res_valid pulse occurs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge causes the block to latch op_a. It latches op_b, inverted if sub=1.
  - Carry register is loaded with (sub ? 1 : cin). Byte index = 0, busy=1, next state is RUN.
  - start=0: remain in IDLE.
- RUN, one byte per cycle:
  - The adder receives A[idx], B'[idx] and the carry register.
  - At the edge, the sum byte is written to result[idx], the carry register takes the adder cout, and idx increments.
  - At the edge where idx = NBYTES-1, also capture:
    - cout = adder cout;
    - ovf = (carry into bit 7 of the top byte) XOR adder cout. The carry into bit 7 is computed as A7 XOR B'7 XOR sum7.
    - zero = (all result bytes, including the byte written in this cycle, equal 0).
  - Then res_valid=1 and the state goes to DONE.
- Latency:
  - start accepted at edge k; res_valid is high after edge k+NBYTES.
  - Exactly NBYTES RUN cycles, no bubbles.
- DONE:
  - result, cout, ovf and zero are held stable while res_valid=1.
  - When res_valid && res_ready at an edge: res_valid=0, busy=0, next state is IDLE. The result fields keep their values until the next operation overwrites them.
  - res_ready=0 holds DONE indefinitely (backpressure).
- Start handling:
  - start while busy=1 (RUN or DONE) is ignored, is not queued and does not disturb the operation in progress.
  - start in the same cycle as the DONE handshake is ignored. A new start is accepted at the earliest one cycle later, in IDLE.
- Stability: op_a, op_b, sub and cin may change freely after acceptance; only the latched copies are used.
- Width rules:
  - result is modulo 2^W.
  - For sub, result = A + ~B + 1, and cout=1 means A >= B as unsigned values.
- res_ready is ignored outside DONE.

Test Plan:
- NBYTES=4, add, A=0x000000FF, B=0x00000001, cin=0 -> after 4 cycles: result=0x00000100, cout=0, ovf=0, zero=0; busy high for exactly 4 cycles plus the handshake.
- Add, A=0xFFFFFFFF, B=0x00000001, cin=0 -> result=0x00000000, cout=1, zero=1, ovf=0. Also check cin=1 with A=B=0 -> result=0x00000001.
- Sub, A=5, B=7 -> result=0xFFFFFFFE, cout=0 (borrow), ovf=0. Sub, A=7, B=5 -> result=0x00000002, cout=1.
- Add, A=0x7FFFFFFF, B=0x00000001 -> result=0x80000000, ovf=1, cout=0. Sub, A=0x80000000, B=1 -> ovf=1.
- Hold res_ready=0 for 10 cycles while pulsing start with new operands -> res_valid, busy and result stay unchanged, the new start is ignored. Then res_ready=1 -> back in IDLE, and the next start is accepted normally.
- Assert rst_n=0 for one edge in the 2nd RUN cycle -> all outputs 0 and state IDLE next cycle, no res_valid. A start issued immediately after reset completes correctly.
